// File: rtl/exe_except_collect_pkg.sv
// Shared EXE exception types, codes and FSM states.
// Imported by the lane checker, the handshake interface and the collector.
package exe_except_collect_pkg;

  typedef struct packed {
    logic Interrupt;
    logic WrongAddressinIF;
    logic TLBRefillinIF;
    logic TLBInvalidinIF;
    logic ReservedInstruction;
    logic CoprocessorUnusable;
    logic Syscall;
    logic Break;
    logic Eret;
    logic Overflow;
    logic Trap;
    logic RdWrongAddressinMEM;
    logic WrWrongAddressinMEM;
    logic RdTLBRefill;
    logic RdTLBInvalid;
    logic WrTLBRefill;
    logic WrTLBInvalid;
    logic TLBModified;
    logic Refetch;
  } ExceptinPipeType;

  typedef struct packed {
    logic       ReadMem;
    logic [1:0] size;
    logic [1:0] LeftOrRight;
  } LoadType;

  typedef struct packed {
    logic       DMWr;
    logic [1:0] size;
    logic [1:0] LeftOrRight;
  } StoreType;

  localparam logic [1:0] LOADTYPE_LW  = 2'b00;
  localparam logic [1:0] LOADTYPE_LH  = 2'b01;
  localparam logic [1:0] STORETYPE_SW = 2'b00;
  localparam logic [1:0] STORETYPE_SH = 2'b01;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_MOD  = 5'd1;
  localparam logic [4:0] EXCCODE_TLBL = 5'd2;
  localparam logic [4:0] EXCCODE_TLBS = 5'd3;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_BP   = 5'd9;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_CPU  = 5'd11;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;
  localparam logic [4:0] EXCCODE_TR   = 5'd13;

  typedef enum logic {RUN, PEND} exc_fsm_t;

  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_lr(input logic [1:0] lr);
    return (lr == 2'b01) || (lr == 2'b10);
  endfunction

endpackage

// File: rtl/exe_except_collect_if.sv
// EXE-side bundle into the exception collector and its
// registered EXE/MEM and CP0-facing results.
interface exe_except_collect_if
  import exe_except_collect_pkg::*;
#(parameter int LANES = 2);
  localparam int LW = lane_w(LANES);

  logic [LANES-1:0]             ex_valid;
  logic [LANES-1:0][31:0]       ex_pc;
  logic [LANES-1:0][31:0]       ex_addr;
  ExceptinPipeType [LANES-1:0]  ex_except;
  logic [LANES-1:0]             ex_overflow;
  logic [LANES-1:0]             ex_trap;
  logic [LANES-1:0]             ex_refetch;
  LoadType [LANES-1:0]          ex_load;
  StoreType [LANES-1:0]         ex_store;
  logic                         mem_stall;
  logic                         flush;
  logic                         exc_ack;
  logic                         ex_allowin;
  logic [LANES-1:0]             mem_valid;
  ExceptinPipeType [LANES-1:0]  mem_except;
  logic                         exc_req;
  logic [LW-1:0]                exc_lane;
  logic [4:0]                   exc_code;
  logic                         exc_is_eret;
  logic                         exc_is_refetch;
  logic [31:0]                  exc_pc;
  logic [31:0]                  exc_badvaddr;

  modport master (
    output ex_valid, ex_pc, ex_addr, ex_except,
    output ex_overflow, ex_trap, ex_refetch,
    output ex_load, ex_store,
    output mem_stall, flush, exc_ack,
    input  ex_allowin, mem_valid, mem_except,
    input  exc_req, exc_lane, exc_code,
    input  exc_is_eret, exc_is_refetch,
    input  exc_pc, exc_badvaddr
  );

  modport slave (
    input  ex_valid, ex_pc, ex_addr, ex_except,
    input  ex_overflow, ex_trap, ex_refetch,
    input  ex_load, ex_store,
    input  mem_stall, flush, exc_ack,
    output ex_allowin, mem_valid, mem_except,
    output exc_req, exc_lane, exc_code,
    output exc_is_eret, exc_is_refetch,
    output exc_pc, exc_badvaddr
  );
endinterface

// File: rtl/exe_except_collect_lane.sv
// Per-lane EXE exception check: final vector, hit,
// highest-priority ExcCode and BadVAddr for one lane.
module exe_except_lane
  import exe_except_collect_pkg::*;
#(parameter bit ALIGN_LR_EXEMPT = 1'b1) (
  input  logic            valid,
  input  logic [31:0]     pc,
  input  logic [31:0]     addr,
  input  ExceptinPipeType except_i,
  input  logic            overflow,
  input  logic            trap,
  input  logic            refetch,
  input  LoadType         load,
  input  StoreType        store,
  output ExceptinPipeType except_o,
  output logic            hit,
  output logic [4:0]      code,
  output logic            is_eret,
  output logic            is_refetch,
  output logic [31:0]     badvaddr
);
  logic rd_ex, wr_ex, rd_bad, wr_bad;

  always_comb begin
    rd_ex  = ALIGN_LR_EXEMPT && is_lr(load.LeftOrRight);
    wr_ex  = ALIGN_LR_EXEMPT && is_lr(store.LeftOrRight);
    rd_bad = load.ReadMem && !rd_ex &&
             ((load.size == LOADTYPE_LW && addr[1:0] != 2'b00) ||
              (load.size == LOADTYPE_LH && addr[0]));
    wr_bad = store.DMWr && !wr_ex &&
             ((store.size == STORETYPE_SW && addr[1:0] != 2'b00) ||
              (store.size == STORETYPE_SH && addr[0]));

    except_o = except_i;
    except_o.WrongAddressinIF    = pc[1:0] != 2'b00;
    except_o.RdWrongAddressinMEM = rd_bad;
    except_o.WrWrongAddressinMEM = wr_bad;
    except_o.Overflow            = overflow;
    except_o.Trap                = trap;
    except_o.Refetch             = except_i.Refetch | refetch;

    hit        = valid && (|except_o);
    code       = EXCCODE_INT;
    is_eret    = 1'b0;
    is_refetch = 1'b0;
    badvaddr   = '0;

    if (except_o.Interrupt) code = EXCCODE_INT;
    else if (except_o.WrongAddressinIF) begin
      code = EXCCODE_ADEL; badvaddr = pc;
    end else if (except_o.TLBRefillinIF || except_o.TLBInvalidinIF) begin
      code = EXCCODE_TLBL; badvaddr = pc;
    end else if (except_o.ReservedInstruction) code = EXCCODE_RI;
    else if (except_o.CoprocessorUnusable) code = EXCCODE_CPU;
    else if (except_o.Syscall) code = EXCCODE_SYS;
    else if (except_o.Break) code = EXCCODE_BP;
    else if (except_o.Eret) is_eret = 1'b1;
    else if (except_o.Overflow) code = EXCCODE_OV;
    else if (except_o.Trap) code = EXCCODE_TR;
    else if (except_o.RdWrongAddressinMEM) begin
      code = EXCCODE_ADEL; badvaddr = addr;
    end else if (except_o.WrWrongAddressinMEM) begin
      code = EXCCODE_ADES; badvaddr = addr;
    end else if (except_o.RdTLBRefill || except_o.RdTLBInvalid) begin
      code = EXCCODE_TLBL; badvaddr = addr;
    end else if (except_o.WrTLBRefill || except_o.WrTLBInvalid) begin
      code = EXCCODE_TLBS; badvaddr = addr;
    end else if (except_o.TLBModified) begin
      code = EXCCODE_MOD; badvaddr = addr;
    end else if (except_o.Refetch) is_refetch = 1'b1;
  end
endmodule

// File: rtl/exe_except_collect.sv
// Multi-lane EXE exception collector: first-hit select, younger-lane
// kill, EXE/MEM registers and the RUN/PEND handshake with CP0.
module exe_except_collect
  import exe_except_collect_pkg::*;
#(
  parameter int LANES           = 2,
  parameter bit ALIGN_LR_EXEMPT = 1'b1
) (
  input logic               clk,
  input logic               resetn,
  exe_except_collect_if.slave bus
);
  localparam int LW = lane_w(LANES);

  ExceptinPipeType [LANES-1:0] fin;
  logic [LANES-1:0]            hit, eret, rfch, keep;
  logic [LANES-1:0][4:0]       code;
  logic [LANES-1:0][31:0]      badv;
  logic                        any_hit, allowin;
  logic [LW-1:0]               first;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    exe_except_lane #(.ALIGN_LR_EXEMPT(ALIGN_LR_EXEMPT)) u_lane (
      .valid     (bus.ex_valid[g]),
      .pc        (bus.ex_pc[g]),
      .addr      (bus.ex_addr[g]),
      .except_i  (bus.ex_except[g]),
      .overflow  (bus.ex_overflow[g]),
      .trap      (bus.ex_trap[g]),
      .refetch   (bus.ex_refetch[g]),
      .load      (bus.ex_load[g]),
      .store     (bus.ex_store[g]),
      .except_o  (fin[g]),
      .hit       (hit[g]),
      .code      (code[g]),
      .is_eret   (eret[g]),
      .is_refetch(rfch[g]),
      .badvaddr  (badv[g])
    );
  end

  exc_fsm_t                    state_q, state_d;
  logic [LANES-1:0]            valid_q, valid_d;
  ExceptinPipeType [LANES-1:0] exv_q, exv_d;
  logic [LW-1:0]               lane_q, lane_d;
  logic [4:0]                  code_q, code_d;
  logic                        eret_q, eret_d;
  logic                        rfch_q, rfch_d;
  logic [31:0]                 pc_q, pc_d;
  logic [31:0]                 badv_q, badv_d;

  always_comb begin
    any_hit = |hit;
    first   = '0;
    for (int i = LANES - 1; i >= 0; i--)
      if (hit[i]) first = LW'(i);
    // younger lanes than the first excepting one never reach MEM
    for (int i = 0; i < LANES; i++)
      keep[i] = bus.ex_valid[i] && !(any_hit && (i > int'(first)));
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    exv_d   = exv_q;
    lane_d  = lane_q;
    code_d  = code_q;
    eret_d  = eret_q;
    rfch_d  = rfch_q;
    pc_d    = pc_q;
    badv_d  = badv_q;
    allowin = 1'b0;
    unique case (state_q)
      RUN: begin
        allowin = !bus.mem_stall;
        if (allowin) begin
          valid_d = keep;
          for (int i = 0; i < LANES; i++)
            exv_d[i] = keep[i] ? fin[i] : '0;
          lane_d = any_hit ? first : '0;
          code_d = any_hit ? code[first] : '0;
          eret_d = any_hit && eret[first];
          rfch_d = any_hit && rfch[first];
          pc_d   = any_hit ? bus.ex_pc[first] : '0;
          badv_d = any_hit ? badv[first] : '0;
          if (any_hit) state_d = PEND;
        end
      end
      PEND: begin
        if (bus.exc_ack) begin
          valid_d = '0;
          lane_d  = '0;
          code_d  = '0;
          eret_d  = 1'b0;
          rfch_d  = 1'b0;
          pc_d    = '0;
          badv_d  = '0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (bus.flush) begin
      state_d = RUN;
      valid_d = '0;
      exv_d   = '0;
      lane_d  = '0;
      code_d  = '0;
      eret_d  = 1'b0;
      rfch_d  = 1'b0;
      pc_d    = '0;
      badv_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      valid_q <= '0;
      exv_q   <= '0;
      lane_q  <= '0;
      code_q  <= '0;
      eret_q  <= 1'b0;
      rfch_q  <= 1'b0;
      pc_q    <= '0;
      badv_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      exv_q   <= exv_d;
      lane_q  <= lane_d;
      code_q  <= code_d;
      eret_q  <= eret_d;
      rfch_q  <= rfch_d;
      pc_q    <= pc_d;
      badv_q  <= badv_d;
    end
  end

  assign bus.ex_allowin     = allowin;
  assign bus.mem_valid      = valid_q;
  assign bus.mem_except     = exv_q;
  assign bus.exc_req        = (state_q == PEND);
  assign bus.exc_lane       = lane_q;
  assign bus.exc_code       = code_q;
  assign bus.exc_is_eret    = eret_q;
  assign bus.exc_is_refetch = rfch_q;
  assign bus.exc_pc         = pc_q;
  assign bus.exc_badvaddr   = badv_q;
endmodule

// File: tb/tb_exe_except_collect.sv
// Directed bench for exe_except_collect: two instances differing
// only in LR alignment exemption share one stimulus set.
module tb_exe_except_collect;
  import exe_except_collect_pkg::*;

  logic clk;
  logic resetn;

  logic [1:0]            ex_valid;
  logic [1:0][31:0]      ex_pc, ex_addr;
  ExceptinPipeType [1:0] ex_except;
  logic [1:0]            ex_ov, ex_tr, ex_rf;
  LoadType [1:0]         ex_ld;
  StoreType [1:0]        ex_st;
  logic                  mem_stall, flush, exc_ack;

  int n_run;
  int n_fail;

  exe_except_collect_if #(.LANES(2)) ifa ();
  exe_except_collect_if #(.LANES(2)) ifb ();

  assign ifa.ex_valid    = ex_valid;
  assign ifa.ex_pc       = ex_pc;
  assign ifa.ex_addr     = ex_addr;
  assign ifa.ex_except   = ex_except;
  assign ifa.ex_overflow = ex_ov;
  assign ifa.ex_trap     = ex_tr;
  assign ifa.ex_refetch  = ex_rf;
  assign ifa.ex_load     = ex_ld;
  assign ifa.ex_store    = ex_st;
  assign ifa.mem_stall   = mem_stall;
  assign ifa.flush       = flush;
  assign ifa.exc_ack     = exc_ack;

  assign ifb.ex_valid    = ex_valid;
  assign ifb.ex_pc       = ex_pc;
  assign ifb.ex_addr     = ex_addr;
  assign ifb.ex_except   = ex_except;
  assign ifb.ex_overflow = ex_ov;
  assign ifb.ex_trap     = ex_tr;
  assign ifb.ex_refetch  = ex_rf;
  assign ifb.ex_load     = ex_ld;
  assign ifb.ex_store    = ex_st;
  assign ifb.mem_stall   = mem_stall;
  assign ifb.flush       = flush;
  assign ifb.exc_ack     = exc_ack;

  exe_except_collect #(.LANES(2), .ALIGN_LR_EXEMPT(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .bus(ifa)
  );
  exe_except_collect #(.LANES(2), .ALIGN_LR_EXEMPT(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    ex_valid  = '0;
    ex_pc     = '0;
    ex_addr   = '0;
    ex_except = '0;
    ex_ov     = '0;
    ex_tr     = '0;
    ex_rf     = '0;
    ex_ld     = '0;
    ex_st     = '0;
    exc_ack   = 1'b0;
  endtask

  task automatic ack();
    clr_in();
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    resetn = 1'b1;
    mem_stall = 1'b0;
    flush = 1'b0;
    clr_in();
    #3 resetn = 1'b0;
    #1;
    chk("rst_req",    64'(ifa.exc_req), 64'd0);
    chk("rst_valid",  64'(ifa.mem_valid), 64'd0);
    chk("rst_code",   64'(ifa.exc_code), 64'd0);
    chk("rst_pc",     64'(ifa.exc_pc), 64'd0);
    chk("rst_allow",  64'(ifa.ex_allowin), 64'd1);
    @(negedge clk);
    resetn = 1'b1;

    // LW misaligned in lane 0, overflow in lane 1 is killed
    ex_valid = 2'b11;
    ex_pc[0] = 32'h0040_0000; ex_pc[1] = 32'h0040_0004;
    ex_addr[0] = 32'h0000_1002;
    ex_ld[0] = '{ReadMem: 1'b1, size: 2'b00, LeftOrRight: 2'b00};
    ex_ov[1] = 1'b1;
    step();
    chk("t1_req",   64'(ifa.exc_req), 64'd1);
    chk("t1_lane",  64'(ifa.exc_lane), 64'd0);
    chk("t1_code",  64'(ifa.exc_code), 64'd4);
    chk("t1_badv",  64'(ifa.exc_badvaddr), 64'h1002);
    chk("t1_pc",    64'(ifa.exc_pc), 64'h40_0000);
    chk("t1_valid", 64'(ifa.mem_valid), 64'd1);
    chk("t1_exv0",  64'(ifa.mem_except[0].RdWrongAddressinMEM), 64'd1);
    chk("t1_exv1",  64'(ifa.mem_except[1].Overflow), 64'd0);
    chk("t1_allow", 64'(ifa.ex_allowin), 64'd0);
    clr_in();
    step(); step();
    chk("t1_hold_req",  64'(ifa.exc_req), 64'd1);
    chk("t1_hold_code", 64'(ifa.exc_code), 64'd4);
    chk("t1_hold_allow", 64'(ifa.ex_allowin), 64'd0);
    ack();
    chk("t1_ack_req",   64'(ifa.exc_req), 64'd0);
    chk("t1_ack_valid", 64'(ifa.mem_valid), 64'd0);
    chk("t1_ack_code",  64'(ifa.exc_code), 64'd0);
    chk("t1_ack_allow", 64'(ifa.ex_allowin), 64'd1);

    // LWL at 0x1003: exempt in dut_a, ADEL in dut_b
    ex_valid = 2'b01;
    ex_pc[0] = 32'h0040_0100;
    ex_addr[0] = 32'h0000_1003;
    ex_ld[0] = '{ReadMem: 1'b1, size: 2'b00, LeftOrRight: 2'b01};
    step();
    chk("t2a_req",   64'(ifa.exc_req), 64'd0);
    chk("t2a_valid", 64'(ifa.mem_valid), 64'd1);
    chk("t2b_req",   64'(ifb.exc_req), 64'd1);
    chk("t2b_code",  64'(ifb.exc_code), 64'd4);
    chk("t2b_badv",  64'(ifb.exc_badvaddr), 64'h1003);
    ack();
    chk("t2a_ack_ign", 64'(ifa.exc_req), 64'd0);
    chk("t2b_ack",     64'(ifb.exc_req), 64'd0);

    // IF address error beats syscall
    ex_valid = 2'b01;
    ex_pc[0] = 32'hBFC0_0001;
    ex_except[0].Syscall = 1'b1;
    step();
    chk("t3_code", 64'(ifa.exc_code), 64'd4);
    chk("t3_badv", 64'(ifa.exc_badvaddr), 64'hBFC0_0001);
    chk("t3_pc",   64'(ifa.exc_pc), 64'hBFC0_0001);
    ack();

    // ERET in lane 0
    ex_valid = 2'b11;
    ex_pc[0] = 32'h0000_0300; ex_pc[1] = 32'h0000_0304;
    ex_except[0].Eret = 1'b1;
    step();
    chk("te_req",   64'(ifa.exc_req), 64'd1);
    chk("te_eret",  64'(ifa.exc_is_eret), 64'd1);
    chk("te_code",  64'(ifa.exc_code), 64'd0);
    chk("te_valid", 64'(ifa.mem_valid), 64'd1);
    ack();

    // refetch request from EXE on lane 1
    ex_valid = 2'b11;
    ex_pc[0] = 32'h0000_0400; ex_pc[1] = 32'h0000_0404;
    ex_rf[1] = 1'b1;
    step();
    chk("tr_rf",    64'(ifa.exc_is_refetch), 64'd1);
    chk("tr_lane",  64'(ifa.exc_lane), 64'd1);
    chk("tr_exv",   64'(ifa.mem_except[1].Refetch), 64'd1);
    chk("tr_badv",  64'(ifa.exc_badvaddr), 64'd0);
    ack();

    // SH misaligned in lane 1, lane 0 clean
    ex_valid = 2'b11;
    ex_pc[0] = 32'h0000_0100; ex_pc[1] = 32'h0000_0104;
    ex_addr[1] = 32'h0000_2001;
    ex_st[1] = '{DMWr: 1'b1, size: 2'b01, LeftOrRight: 2'b00};
    step();
    chk("t4_lane",  64'(ifa.exc_lane), 64'd1);
    chk("t4_code",  64'(ifa.exc_code), 64'd5);
    chk("t4_valid", 64'(ifa.mem_valid), 64'd3);
    chk("t4_badv",  64'(ifa.exc_badvaddr), 64'h2001);
    chk("t4_pc",    64'(ifa.exc_pc), 64'h104);

    // flush and ack together while pending
    clr_in();
    flush = 1'b1;
    exc_ack = 1'b1;
    step();
    flush = 1'b0;
    exc_ack = 1'b0;
    chk("t5_req",   64'(ifa.exc_req), 64'd0);
    chk("t5_valid", 64'(ifa.mem_valid), 64'd0);
    chk("t5_code",  64'(ifa.exc_code), 64'd0);
    chk("t5_lane",  64'(ifa.exc_lane), 64'd0);
    chk("t5_badv",  64'(ifa.exc_badvaddr), 64'd0);
    chk("t5_exv",   64'(ifa.mem_except), 64'd0);
    chk("t5_allow", 64'(ifa.ex_allowin), 64'd1);

    // stall holds the EXE/MEM registers
    ex_valid = 2'b11;
    ex_pc[0] = 32'h0000_0200; ex_pc[1] = 32'h0000_0204;
    step();
    chk("t6_valid", 64'(ifa.mem_valid), 64'd3);
    chk("t6_req",   64'(ifa.exc_req), 64'd0);
    mem_stall = 1'b1;
    ex_valid = 2'b01;
    ex_tr[0] = 1'b1;
    step(); step(); step();
    chk("t6_stall_valid", 64'(ifa.mem_valid), 64'd3);
    chk("t6_stall_req",   64'(ifa.exc_req), 64'd0);
    chk("t6_stall_allow", 64'(ifa.ex_allowin), 64'd0);
    mem_stall = 1'b0;
    #1;
    chk("t6_allow", 64'(ifa.ex_allowin), 64'd1);
    step();
    chk("t6_tr_req",   64'(ifa.exc_req), 64'd1);
    chk("t6_tr_code",  64'(ifa.exc_code), 64'd13);
    chk("t6_tr_valid", 64'(ifa.mem_valid), 64'd1);
    chk("t6_pend_allow", 64'(ifa.ex_allowin), 64'd0);

    // asynchronous reset while pending
    #2 resetn = 1'b0;
    #1;
    chk("t6_arst_req",   64'(ifa.exc_req), 64'd0);
    chk("t6_arst_valid", 64'(ifa.mem_valid), 64'd0);
    chk("t6_arst_code",  64'(ifa.exc_code), 64'd0);
    resetn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
